imem_loader: RTL

- Write-side counterpart of the instruction ROM read path: the fetch stage only reads instruction memory, this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction RAM at consecutive word addresses.
- Holds the pipeline (pc_reg and downstream stages) in reset via core_hold_o until the load completes.

---
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction RAM and holds the core until loaded
// Optional IMEM_LOADER_CHKSUM_EN: trailing mod-256 checksum byte verified in state CHK.
module imem_loader #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              core_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
`ifdef IMEM_LOADER_CHKSUM_EN
    ST_CHK,
`endif
    ST_ERR
  } state_t;

  state_t            state_q;
  logic [1:0]        byte_cnt_q;
  logic [15:0]       word_cnt_q;
  logic [15:0]       len_q;
  logic [23:0]       shift_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic [ADDR_W-1:0] word_addr_d;
  logic [15:0]       word_cnt_d;
  logic [DATA_W-1:0] word_d;
  logic              len_too_big_d;

  // Lane 3 is never stored: it completes the word straight from byte_i.
  assign word_addr_d   = BASE_ADDR + (ADDR_W'(word_cnt_q) << 2);
  assign word_cnt_d    = word_cnt_q + 16'd1;
  assign word_d        = {byte_i, shift_q};
  assign len_too_big_d = ({16'd0, len_i} > 32'(DEPTH_WORDS));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= 16'd0;
      len_q        <= 16'd0;
      shift_q      <= 24'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            shift_q    <= 24'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q      <= 8'd0;
`endif
            if (len_i == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state_q      <= ST_CHK;
              byte_ready_q <= 1'b1;
              core_hold_q  <= 1'b1;
              done_q       <= 1'b0;
`else
              state_q      <= ST_DONE;
              byte_ready_q <= 1'b0;
              core_hold_q  <= 1'b0;
              done_q       <= 1'b1;
`endif
              busy_q       <= 1'b0;
              err_q        <= 1'b0;
            end else if (len_too_big_d) begin
              state_q      <= ST_ERR;
              byte_ready_q <= 1'b0;
              core_hold_q  <= 1'b1;
              busy_q       <= 1'b0;
              done_q       <= 1'b0;
              err_q        <= 1'b1;
            end else begin
              state_q      <= ST_RECV;
              len_q        <= len_i;
              byte_ready_q <= 1'b1;
              core_hold_q  <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              err_q        <= 1'b0;
            end
          end
        end

        ST_RECV: begin
          if (byte_valid_i) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q      <= sum_q + byte_i;
`endif
            case (byte_cnt_q)
              2'd0: shift_q[7:0]   <= byte_i;
              2'd1: shift_q[15:8]  <= byte_i;
              2'd2: shift_q[23:16] <= byte_i;
              default: begin
                state_q      <= ST_WRITE;
                byte_ready_q <= 1'b0;
                mem_we_q     <= 1'b1;
                mem_addr_q   <= word_addr_d;
                mem_wdata_q  <= word_d;
              end
            endcase
          end
        end

        ST_WRITE: begin
          word_cnt_q <= word_cnt_d;
          if (word_cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            state_q      <= ST_CHK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= ST_DONE;
            byte_ready_q <= 1'b0;
            core_hold_q  <= 1'b0;
            done_q       <= 1'b1;
`endif
            busy_q       <= 1'b0;
          end else begin
            state_q      <= ST_RECV;
            byte_ready_q <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHKSUM_EN
        ST_CHK: begin
          if (byte_valid_i) begin
            byte_ready_q <= 1'b0;
            if (byte_i == sum_q) begin
              state_q     <= ST_DONE;
              core_hold_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q     <= ST_ERR;
              core_hold_q <= 1'b1;
              err_q       <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b0;
          core_hold_q  <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign core_hold_o  = core_hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
